// File: rtl/datamemory_arbiter_pkg.sv
// Shared types and default widths for the two-requester data-memory arbiter.
package dm_arb_pkg;
  localparam int NBITS_O_DEF = 11;
  localparam int NBITS_D_DEF = 16;
  localparam int CELDAS_DEF  = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: the requester not granted last wins a tie.
// Purely combinational; one-hot (or zero) grant.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_gnt)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end
endmodule

// File: rtl/datamemory_arbiter.sv
// Shares one data memory between the pipeline (0) and the debug unit (1).
// Request -> grant next cycle -> valid/rdata the cycle after; one access per two cycles.
module datamemory_arbiter
  import dm_arb_pkg::*;
#(
  parameter int NBITS_O = NBITS_O_DEF,
  parameter int NBITS_D = NBITS_D_DEF,
  parameter int CELDAS  = CELDAS_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic               i_wr0,
  input  logic               i_wr1,
  input  logic [NBITS_O-1:0] i_add0,
  input  logic [NBITS_O-1:0] i_add1,
  input  logic [NBITS_D-1:0] i_data0,
  input  logic [NBITS_D-1:0] i_data1,
  output logic               o_gnt0,
  output logic               o_gnt1,
  output logic               o_valid0,
  output logic               o_valid1,
  output logic               o_err,
  output logic [NBITS_D-1:0] o_rdata,
  output logic               o_busy,
  output logic               o_mem_Rd,
  output logic               o_mem_Wr,
  output logic [NBITS_O-1:0] o_mem_Add,
  output logic [NBITS_D-1:0] o_mem_InData,
  input  logic [NBITS_D-1:0] i_mem_OutData
);
  state_t             state_q, state_d;
  logic               win_q, win_d;
  logic               last_q, last_d;
  logic               armed_q;
  logic               err_q;
  logic [NBITS_D-1:0] rdata_q;
  logic [1:0]         arb_gnt;

  logic               sel_wr;
  logic [NBITS_O-1:0] sel_add;
  logic [NBITS_D-1:0] sel_data;
  logic               sel_oor;

  rr_arbiter2 u_rr (
    .req      ({i_req1, i_req0}),
    .last_gnt (last_q),
    .gnt      (arb_gnt)
  );

  assign sel_wr   = win_q ? i_wr1   : i_wr0;
  assign sel_add  = win_q ? i_add1  : i_add0;
  assign sel_data = win_q ? i_data1 : i_data0;
  assign sel_oor  = 32'(sel_add) >= 32'(CELDAS);

  assign o_busy  = (state_q != IDLE);
  assign o_rdata = rdata_q;

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    last_d       = last_q;
    o_gnt0       = 1'b0;
    o_gnt1       = 1'b0;
    o_valid0     = 1'b0;
    o_valid1     = 1'b0;
    o_err        = 1'b0;
    o_mem_Rd     = 1'b0;
    o_mem_Wr     = 1'b0;
    o_mem_Add    = '0;
    o_mem_InData = '0;
    case (state_q)
      IDLE: begin
        // armed_q holds off the first grant until one full clock after reset release
        if (armed_q && (arb_gnt != 2'b00)) begin
          win_d   = arb_gnt[1];
          last_d  = arb_gnt[1];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        o_gnt0       = !win_q;
        o_gnt1       = win_q;
        o_mem_Add    = sel_add;
        o_mem_InData = sel_data;
        o_mem_Rd     = !sel_oor && !sel_wr;
        o_mem_Wr     = !sel_oor && sel_wr;
        state_d      = DONE;
      end
      DONE: begin
        o_valid0 = !win_q;
        o_valid1 = win_q;
        o_err    = err_q;
        // only the other side may be granted straight from DONE
        if (win_q ? i_req0 : i_req1) begin
          win_d   = !win_q;
          last_d  = !win_q;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      armed_q <= 1'b1;
      if (state_q == ACCESS) begin
        err_q <= sel_oor;
        if (sel_oor) begin
          rdata_q <= '0;
        end else if (!sel_wr) begin
          rdata_q <= i_mem_OutData;
        end
      end
    end
  end
endmodule

// File: doc/datamemory_arbiter.md
DATAMEMORY_ARBITER -- requirements
Module: datamemory_arbiter

Interface
REQ-001 Parameter NBITS_O, default 11, address width.
REQ-002 Parameter NBITS_D, default 16, data width.
REQ-003 Parameter CELDAS, default 512, number of valid memory words.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 i_clock  in  1  sole clock; all state changes on rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_req0 / i_req1  in  1  access request, requester 0 (pipeline) / 1 (debug unit).
REQ-008 i_wr0 / i_wr1  in  1  1 = write, 0 = read.
REQ-009 i_add0 / i_add1  in  NBITS_O  word address.
REQ-010 i_data0 / i_data1  in  NBITS_D  write data.
REQ-011 o_gnt0 / o_gnt1  out  1  requester owns memory this cycle.
REQ-012 o_valid0 / o_valid1  out  1  one-cycle completion pulse.
REQ-013 o_err  out  1  out-of-range access; coincident with o_validN.
REQ-014 o_rdata  out  NBITS_D  registered read data, shared by both requesters.
REQ-015 o_busy  out  1  high in any state other than IDLE.
REQ-016 o_mem_Rd, o_mem_Wr  out  1  memory strobes.
REQ-017 o_mem_Add  out  NBITS_O  memory address.
REQ-018 o_mem_InData  out  NBITS_D  memory write data.
REQ-019 i_mem_OutData  in  NBITS_D  memory read data.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-021 IDLE: if any i_reqN is high, pick a winner (REQ-024) and go to ACCESS; otherwise stay in IDLE.
REQ-022 ACCESS, one cycle:
- o_gntN = 1 for the winner only.
- o_mem_Add and o_mem_InData driven from the winner's inputs.
- Exactly one of o_mem_Rd / o_mem_Wr = 1 according to i_wrN.
- Then go to DONE.
REQ-023 DONE:
- o_validN pulses for the winner.
- On a read, o_rdata holds i_mem_OutData as captured on the ACCESS->DONE edge.
- On a write, o_rdata keeps its previous value.
- If the other requester's request is high, grant it and go to ACCESS; otherwise go to IDLE.
REQ-024 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins. The last-grant pointer updates on each entry to ACCESS.
REQ-025 Latency: request sampled at edge N -> o_gnt high in cycle N+1 -> o_valid and o_rdata in cycle N+2. Peak throughput is one access per two cycles.
REQ-026 Requesters SHALL hold i_req, i_wr, i_add and i_data stable until o_valid, then drop i_req in that same cycle. The block SHALL NOT re-grant the requester completing in DONE.
REQ-027 Outside ACCESS, o_mem_Rd and o_mem_Wr SHALL be 0 and o_mem_Add and o_mem_InData SHALL be 0.
REQ-028 If i_addN >= CELDAS:
- No memory strobe in ACCESS.
- o_err = 1 with o_validN in DONE.
- o_rdata is forced to 0.
REQ-029 A request dropped before its grant SHALL be ignored and SHALL NOT move the pointer.

Reset
REQ-030 While i_reset is 0, asynchronously and independent of i_clock:
- state = IDLE.
- All o_gnt, o_valid, o_err, o_busy and memory strobes = 0.
- o_rdata = 0.
- Pointer = "last granted 1", so requester 0 wins the first tie.
REQ-031 Reset during ACCESS SHALL drop the strobes immediately. That access produces no o_valid, and its write may be partial or lost.
REQ-032 The first grant SHALL occur no earlier than the second rising edge after i_reset rises.

Structure
REQ-033 State encodings and default widths SHALL live in the shared package dm_arb_pkg.
REQ-034 Round-robin winner selection SHALL be the sub-module rr_arbiter2:
- Inputs: two requests, pointer.
- Output: one-hot grant.
- Purely combinational.
REQ-035 The FSM, pointer and o_rdata register SHALL live in datamemory_arbiter.

Verification
REQ-036 Single read: preload word 5 = 0xBEEF; i_req0 read addr 5 at edge 0 -> o_gnt0 cycle 1 with o_mem_Rd = 1 and o_mem_Add = 5 -> o_valid0 cycle 2 with o_rdata = 0xBEEF.
REQ-037 Write then read: req1 writes 0x1234 to addr 7, then reads addr 7 -> o_mem_Wr high exactly one cycle; read returns 0x1234.
REQ-038 Tie after reset: both requesters request at edge 0 -> req0 granted cycle 1, req1 granted cycle 3 (DONE->ACCESS); both held continuously -> strict alternation.
REQ-039 Out of range: req0 reads addr 512 -> no strobes; o_valid0 = o_err = 1 and o_rdata = 0 in cycle 2.
REQ-040 Reset mid-access: assert i_reset low during ACCESS of a write -> strobes and o_gnt fall without a clock edge; no o_valid; after release, req0 wins the next tie.
